// File: rtl/sram_bist_pkg.sv
// sram_bist_pkg: shared BIST types and the March C- op decode used by the SRAM test unit
package sram_bist_pkg;
  typedef enum logic {ZERO_ONE, CHECKER} bist_pattern;
  typedef enum logic [2:0] {E0, E1, E2, E3, E4, E5} march_elem_t;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} bist_state_t;
  typedef struct packed {logic rd; logic bg1;} march_op_t;
  function automatic march_op_t op_of(march_elem_t e, logic sub);
    logic two;
    two = e inside {E1, E2, E3, E4};
    return '{rd: two ? !sub : e == E5, bg1: two && ((e == E2 || e == E4) ^ sub)};
  endfunction
endpackage

// File: rtl/sram_bist_checker.sv
// sram_bist_checker: read-tag pipe aligned to SRAM latency, compare, sticky fail and first-fail capture
module sram_bist_checker #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rstb,
  input  logic                  clr,
  input  logic                  rd,
  input  logic [DATA_WIDTH-1:0] exp_data,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [2:0]            elem,
  input  logic [DATA_WIDTH-1:0] dout,
  output logic                  fail,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [2:0]            fail_elem
);
  typedef struct packed {
    logic                  v;
    logic [DATA_WIDTH-1:0] d;
    logic [ADDR_WIDTH-1:0] a;
    logic [2:0]            e;
  } tag_t;
  tag_t pipe [READ_LATENCY];
  tag_t tail;
  logic miss;
  assign tail = pipe[READ_LATENCY-1];
  assign miss = tail.v && dout != tail.d;
  always_ff @(posedge clk or negedge rstb)
    if (!rstb) begin
      for (int i = 0; i < READ_LATENCY; i++) pipe[i] <= '0;
      fail <= 1'b0;
      fail_addr <= '0;
      fail_elem <= '0;
    end else if (clr) begin
      for (int i = 0; i < READ_LATENCY; i++) pipe[i] <= '0;
      fail <= 1'b0;
      fail_addr <= '0;
      fail_elem <= '0;
    end else begin
      pipe[0] <= {rd, exp_data, addr, elem};
      for (int i = 1; i < READ_LATENCY; i++) pipe[i] <= pipe[i-1];
      if (miss && !fail) begin
        fail <= 1'b1;
        fail_addr <= tail.a;
        fail_elem <= tail.e;
      end
    end
endmodule

// File: rtl/sram_bist_march_ctl.sv
// sram_bist_march_ctl: March C- BIST sequencer driving one SRAM macro and checking its read data
module sram_bist_march_ctl import sram_bist_pkg::*; #(
  parameter int MAX_ADDR = 31,
  parameter int DATA_WIDTH = 32,
  parameter int MASK_WIDTH = 4,
  parameter int READ_LATENCY = 1,
  localparam int ADDR_WIDTH = $clog2(MAX_ADDR + 1)
) (
  input  logic                  clk,
  input  logic                  rstb,
  input  logic                  bist_en,
  input  bist_pattern           bist_pattern_sel,
  output logic                  sram_ce,
  output logic                  sram_we,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_din,
  output logic [MASK_WIDTH-1:0] sram_wmask,
  input  logic [DATA_WIDTH-1:0] sram_dout,
  output logic                  bist_busy,
  output logic                  bist_done,
  output logic                  bist_fail,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [2:0]            fail_elem
);
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(MAX_ADDR);
  localparam int DCW = $clog2(READ_LATENCY + 1);
  bist_state_t state, state_d;
  march_elem_t elem;
  march_op_t op;
  bist_pattern pat;
  logic sub, down, last_sub, term, last_op, run;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DCW-1:0] drain_cnt;
  logic [DATA_WIDTH-1:0] chk, data, exp_q;
  logic [2:0] elem_q;
  always_comb begin
    op = op_of(elem, sub);
    down = elem inside {E3, E4};
    last_sub = !(elem inside {E1, E2, E3, E4}) || sub;
    term = addr == (down ? '0 : LAST);
    last_op = elem == E5 && term;
    run = state == RUN && bist_en;
    for (int i = 0; i < DATA_WIDTH; i++) chk[i] = i[0];
    data = (pat == CHECKER ? chk ^ {DATA_WIDTH{addr[0]}} : '0) ^ {DATA_WIDTH{op.bg1}};
    state_d = !bist_en ? IDLE
            : state == IDLE ? RUN
            : state == RUN && last_op ? DRAIN
            : state == DRAIN && drain_cnt == DCW'(READ_LATENCY) ? DONE
            : state;
  end
  always_ff @(posedge clk or negedge rstb)
    if (!rstb) state <= IDLE;
    else state <= state_d;
  always_ff @(posedge clk or negedge rstb)
    if (!rstb) begin
      elem <= E0;
      sub <= 1'b0;
      addr <= '0;
      pat <= ZERO_ONE;
      drain_cnt <= '0;
      sram_ce <= 1'b0;
      sram_we <= 1'b0;
      sram_addr <= '0;
      sram_din <= '0;
      sram_wmask <= '0;
      exp_q <= '0;
      elem_q <= '0;
    end else begin
      sram_ce <= run;
      sram_we <= run && !op.rd;
      sram_wmask <= run && !op.rd ? '1 : '0;
      sram_din <= run && !op.rd ? data : '0;
      sram_addr <= run ? addr : sram_addr;
      exp_q <= data;
      elem_q <= elem;
      drain_cnt <= state == DRAIN ? drain_cnt + 1'b1 : '0;
      if (state == IDLE) begin
        elem <= E0;
        sub <= 1'b0;
        addr <= '0;
        pat <= bist_pattern_sel;
      end else if (run) begin
        sub <= !last_sub;
        if (last_sub && term && !last_op) begin
          elem <= march_elem_t'(elem + 3'd1);
          addr <= elem inside {E2, E3} ? LAST : '0;
        end else if (last_sub && !term) addr <= down ? addr - 1'b1 : addr + 1'b1;
      end
    end
  assign bist_busy = state inside {RUN, DRAIN};
  assign bist_done = state == DONE;
  sram_bist_checker #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .READ_LATENCY(READ_LATENCY)
  ) u_checker (
    .clk(clk),
    .rstb(rstb),
    .clr(!bist_en),
    .rd(sram_ce && !sram_we),
    .exp_data(exp_q),
    .addr(sram_addr),
    .elem(elem_q),
    .dout(sram_dout),
    .fail(bist_fail),
    .fail_addr(fail_addr),
    .fail_elem(fail_elem)
  );
endmodule

// File: tb/tb_sram_bist_march_ctl.sv
// tb_sram_bist_march_ctl: randomized March C- runs against a faultable SRAM model and a reference march
module tb_sram_bist_march_ctl;
  import sram_bist_pkg::*;
  localparam int N = 32;
  typedef struct {bit we; int a; logic [31:0] d;} op_t;
  logic clk = 1'b0, rstb = 1'b0, bist_en = 1'b0;
  bist_pattern pat_sel = ZERO_ONE;
  logic sram_ce, sram_we, bist_busy, bist_done, bist_fail;
  logic [4:0] sram_addr, fail_addr;
  logic [31:0] sram_din;
  logic [31:0] sram_dout = '0;
  logic [3:0] sram_wmask;
  logic [2:0] fail_elem;
  logic [53:0] all_out;
  logic [31:0] mem [N] = '{default: '0};
  logic [31:0] ref_mem [N];
  int n_cmp = 0, n_bad = 0;
  int fmode = 0, f_a = 0, f_b = 0, f_bit = 0;
  op_t exp_ops[$];
  bit exp_fail;
  int exp_fa, exp_fe;
  int nops [6] = '{1, 2, 2, 2, 2, 1};
  bit dn [6] = '{0, 0, 0, 1, 1, 0};
  bit op_rd [6][2] = '{'{0, 0}, '{1, 0}, '{1, 0}, '{1, 0}, '{1, 0}, '{1, 0}};
  bit op_bg [6][2] = '{'{0, 0}, '{0, 1}, '{1, 0}, '{0, 1}, '{1, 0}, '{0, 0}};
  always #5 clk = ~clk;
  sram_bist_march_ctl dut (
    .clk(clk), .rstb(rstb), .bist_en(bist_en), .bist_pattern_sel(pat_sel),
    .sram_ce(sram_ce), .sram_we(sram_we), .sram_addr(sram_addr), .sram_din(sram_din),
    .sram_wmask(sram_wmask), .sram_dout(sram_dout), .bist_busy(bist_busy), .bist_done(bist_done),
    .bist_fail(bist_fail), .fail_addr(fail_addr), .fail_elem(fail_elem)
  );
  assign all_out = {sram_ce, sram_we, sram_addr, sram_din, sram_wmask, bist_busy, bist_done,
                    bist_fail, fail_addr, fail_elem};
  function automatic int map(int a);
    return fmode == 2 && a == f_a ? f_b : a;
  endfunction
  function automatic logic [31:0] flt(int a, logic [31:0] d);
    return fmode == 1 && a == f_a ? d | (32'd1 << f_bit) : d;
  endfunction
  function automatic logic [31:0] bgd(int pat, int a, bit inv);
    logic [31:0] d;
    d = pat == 1 ? 32'hAAAAAAAA ^ {32{a[0]}} : 32'h0;
    return d ^ {32{inv}};
  endfunction
  always @(posedge clk)
    if (sram_ce) begin
      if (sram_we) mem[map(int'(sram_addr))] <= sram_din;
      else sram_dout <= flt(int'(sram_addr), mem[map(int'(sram_addr))]);
    end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic ref_march(input int pat);
    int a;
    logic [31:0] d;
    exp_ops.delete();
    exp_fail = 0;
    exp_fa = 0;
    exp_fe = 0;
    ref_mem = mem;
    for (int e = 0; e < 6; e++)
      for (int i = 0; i < N; i++) begin
        a = dn[e] ? N - 1 - i : i;
        for (int j = 0; j < nops[e]; j++) begin
          d = bgd(pat, a, op_bg[e][j]);
          if (op_rd[e][j]) begin
            if (flt(a, ref_mem[map(a)]) !== d && !exp_fail) begin
              exp_fail = 1;
              exp_fa = a;
              exp_fe = e;
            end
            exp_ops.push_back('{0, a, d});
          end else begin
            ref_mem[map(a)] = d;
            exp_ops.push_back('{1, a, d});
          end
        end
      end
  endtask
  task automatic run(input int pat, input int abort_at, input int hold);
    op_t o;
    ref_march(pat);
    @(negedge clk);
    pat_sel = bist_pattern'(pat);
    bist_en = 1'b1;
    @(posedge clk);
    #1 check("start", {sram_ce, bist_busy, bist_done}, 3'b010);
    for (int k = 1; k <= 10 * N; k++) begin
      @(posedge clk);
      #1;
      o = exp_ops[k-1];
      check("op", {sram_ce, sram_we, sram_addr, o.we ? sram_din : 32'h0, sram_wmask},
            {1'b1, o.we, 5'(o.a), o.we ? o.d : 32'h0, o.we ? 4'hf : 4'h0});
      if (k == abort_at) begin
        @(negedge clk);
        bist_en = 1'b0;
        @(posedge clk);
        #1 check("abort", {sram_ce, bist_busy, bist_done, bist_fail}, 4'b0);
        repeat (3) @(posedge clk);
        return;
      end
    end
    @(posedge clk);
    #1 check("drain", {sram_ce, bist_busy, bist_done}, 3'b010);
    @(posedge clk);
    #1 check("done", {sram_ce, bist_busy, bist_done}, 3'b001);
    check("fail", bist_fail, exp_fail);
    check("fail_addr", fail_addr, exp_fail ? exp_fa : 0);
    check("fail_elem", fail_elem, exp_fail ? exp_fe : 0);
    repeat (hold) @(posedge clk);
    #1 check("hold_done", {sram_ce, bist_busy, bist_done, bist_fail}, {3'b001, exp_fail});
    @(negedge clk);
    bist_en = 1'b0;
    @(posedge clk);
    #1 check("exit", {bist_done, bist_fail, fail_addr, fail_elem}, 10'b0);
  endtask
  task automatic reset_mid_e3();
    fmode = 0;
    @(negedge clk);
    pat_sel = CHECKER;
    bist_en = 1'b1;
    repeat (201) @(posedge clk);
    #1 check("mid_e3", {sram_ce, bist_busy}, 2'b11);
    #1 rstb = 1'b0;
    #1 check("async_reset", all_out, 54'b0);
    bist_en = 1'b0;
    @(negedge clk);
    rstb = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1 check("idle_after_reset", {sram_ce, bist_busy, bist_done}, 3'b0);
    end
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1 check("reset", all_out, 54'b0);
    @(negedge clk);
    rstb = 1'b1;
    run(0, 0, 2);
    fmode = 1; f_a = 7; f_bit = 5;
    run(0, 0, 2);
    fmode = 2; f_a = 2; f_b = 3;
    run(1, 0, 2);
    fmode = 1; f_a = 0; f_bit = 0;
    run(0, 100, 0);
    fmode = 0;
    run(0, 0, 20);
    reset_mid_e3();
    run(1, 0, 1);
    repeat (8) begin
      fmode = $urandom_range(0, 2);
      f_a = $urandom_range(0, N - 1);
      f_b = (f_a + $urandom_range(1, N - 1)) % N;
      f_bit = $urandom_range(0, 31);
      run($urandom_range(0, 1), $urandom_range(0, 3) == 0 ? $urandom_range(1, 10 * N - 1) : 0,
          $urandom_range(0, 5));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
